// File: rtl/psram_arbiter_pkg.sv
// Shared types and constants for the two-port psram arbiter.
package psram_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 22;

  // Value returned to a reader whose operation was aborted by the watchdog.
  localparam logic [DATA_W-1:0] DEAD_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // One requester's command, exactly as it is latched toward the controller.
  typedef struct packed {
    logic              we;
    logic              bank_sel;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [1:0]        be;
  } cmd_t;

endpackage

// File: rtl/psram_arb_pick.sv
// Combinational winner select between the two requesters.
module psram_arb_pick
  import psram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // A lone requester always wins; a tie goes to port 0 or to the port not served last.
  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b10:   grant = 1'b1;
      2'b11:   grant = (FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a single psram controller: grants one command
// at a time, pulses the controller strobe, and routes read data to the owner.
module psram_arbiter
  import psram_arbiter_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [1:0]             p_req,
  input  logic [1:0]             p_we,
  input  logic [1:0]             p_bank_sel,
  input  logic [1:0][ADDR_W-1:0] p_addr,
  input  logic [1:0][DATA_W-1:0] p_wdata,
  input  logic [1:0][1:0]        p_be,
  output logic [1:0]             p_ack,
  output logic [1:0]             p_rvalid,
  output logic [DATA_W-1:0]      p_rdata,
  output logic                   timeout_err,
  output logic                   mem_bank_sel,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_data_in,
  output logic                   mem_write_high_byte,
  output logic                   mem_write_low_byte,
  output logic                   mem_write_en,
  output logic                   mem_read_en,
  input  logic                   mem_busy,
  input  logic                   mem_read_avail,
  input  logic [DATA_W-1:0]      mem_data_out
);

  localparam bit         WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       owner;
  logic       last_grant;
  logic       we_q;
  logic [7:0] wd_cnt;
  logic       pick_grant;
  logic       pick_valid;
  cmd_t       sel_cmd;

  // Read-available is only a sanity flag for the environment; completion is
  // decided by busy falling, so the arbiter does not consume it.
  logic unused_read_avail;
  assign unused_read_avail = mem_read_avail;

  psram_arb_pick #(
    .FIXED_PRIORITY(FIXED_PRIORITY)
  ) u_pick (
    .req       (p_req),
    .last_grant(last_grant),
    .grant     (pick_grant),
    .valid     (pick_valid)
  );

  // Mux the winning port's fields into one command record.
  always_comb begin
    sel_cmd          = '0;
    sel_cmd.we       = p_we[pick_grant];
    sel_cmd.bank_sel = p_bank_sel[pick_grant];
    sel_cmd.addr     = p_addr[pick_grant];
    sel_cmd.wdata    = p_wdata[pick_grant];
    sel_cmd.be       = p_be[pick_grant];
  end

  // Grant / issue / wait sequencer with registered controller command and responses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      owner               <= 1'b0;
      last_grant          <= 1'b1;
      we_q                <= 1'b0;
      wd_cnt              <= '0;
      p_ack               <= '0;
      p_rvalid            <= '0;
      p_rdata             <= '0;
      timeout_err         <= 1'b0;
      mem_bank_sel        <= 1'b0;
      mem_addr            <= '0;
      mem_data_in         <= '0;
      mem_write_high_byte <= 1'b0;
      mem_write_low_byte  <= 1'b0;
      mem_write_en        <= 1'b0;
      mem_read_en         <= 1'b0;
    end else begin
      p_ack        <= '0;
      p_rvalid     <= '0;
      mem_write_en <= 1'b0;
      mem_read_en  <= 1'b0;
      case (state)
        IDLE: begin
          // Never grant while the controller is still draining an earlier op.
          if (!mem_busy && pick_valid) begin
            mem_bank_sel        <= sel_cmd.bank_sel;
            mem_addr            <= sel_cmd.addr;
            mem_data_in         <= sel_cmd.wdata;
            mem_write_high_byte <= sel_cmd.be[1];
            mem_write_low_byte  <= sel_cmd.be[0];
            we_q                <= sel_cmd.we;
            p_ack[pick_grant]   <= 1'b1;
            owner               <= pick_grant;
            last_grant          <= pick_grant;
            state               <= ISSUE;
          end
        end
        ISSUE: begin
          mem_write_en <= we_q;
          mem_read_en  <= ~we_q;
          wd_cnt       <= '0;
          state        <= WAIT;
        end
        WAIT: begin
          // wd_cnt==0 marks the strobe cycle, before the controller can raise busy.
          if (wd_cnt != 8'd0 && !mem_busy) begin
            if (!we_q) begin
              p_rdata         <= mem_data_out;
              p_rvalid[owner] <= 1'b1;
            end
            state <= IDLE;
          end else if (WD_EN && wd_cnt == WD_LAST) begin
            if (!we_q) begin
              p_rdata         <= DEAD_DATA;
              p_rvalid[owner] <= 1'b1;
            end
            timeout_err <= 1'b1;
            state       <= IDLE;
          end else if (wd_cnt != 8'hFF) begin
            wd_cnt <= wd_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_arbiter.sv
// Bench for psram_arbiter: two instances (round-robin with an 8-cycle
// watchdog, and fixed priority) each driving a behavioural controller stub.
module tb_psram_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // Per-instance request side
  logic [1:0]        p_req      [2];
  logic [1:0]        p_we       [2];
  logic [1:0]        p_bank_sel [2];
  logic [1:0][21:0]  p_addr     [2];
  logic [1:0][15:0]  p_wdata    [2];
  logic [1:0][1:0]   p_be       [2];
  logic [1:0]        p_ack      [2];
  logic [1:0]        p_rvalid   [2];
  logic [15:0]       p_rdata    [2];
  logic              timeout_err[2];
  // Per-instance controller side
  logic              m_bsel [2];
  logic [21:0]       m_addr [2];
  logic [15:0]       m_din  [2];
  logic              m_wh   [2];
  logic              m_wl   [2];
  logic              m_we   [2];
  logic              m_re   [2];
  logic              mem_busy   [2] = '{1'b0, 1'b0};
  logic              mem_ravail [2] = '{1'b0, 1'b0};
  logic [15:0]       mem_dout   [2] = '{16'h0, 16'h0};
  logic [1:0]        stuck = 2'b00;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    psram_arbiter #(
      .FIXED_PRIORITY(i),
      .TIMEOUT_CYCLES(i == 0 ? 8 : 255)
    ) u_dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .p_req              (p_req[i]),
      .p_we               (p_we[i]),
      .p_bank_sel         (p_bank_sel[i]),
      .p_addr             (p_addr[i]),
      .p_wdata            (p_wdata[i]),
      .p_be               (p_be[i]),
      .p_ack              (p_ack[i]),
      .p_rvalid           (p_rvalid[i]),
      .p_rdata            (p_rdata[i]),
      .timeout_err        (timeout_err[i]),
      .mem_bank_sel       (m_bsel[i]),
      .mem_addr           (m_addr[i]),
      .mem_data_in        (m_din[i]),
      .mem_write_high_byte(m_wh[i]),
      .mem_write_low_byte (m_wl[i]),
      .mem_write_en       (m_we[i]),
      .mem_read_en        (m_re[i]),
      .mem_busy           (mem_busy[i]),
      .mem_read_avail     (mem_ravail[i]),
      .mem_data_out       (mem_dout[i])
    );
  end

  function automatic logic [15:0] lane_mask(input logic [1:0] be);
    return {{8{be[1]}}, {8{be[0]}}};
  endfunction

  // Controller stub: strobe raises busy for 1..4 cycles (or forever while stuck),
  // then the op lands in a small word store keyed by {bank, addr[7:0]}.
  logic [15:0] store   [2][512];
  int unsigned stub_cnt[2];
  logic        op_we   [2];
  logic [8:0]  op_key  [2];
  logic [15:0] op_wd   [2];
  logic [1:0]  op_be   [2];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_we[d] || m_re[d]) begin
        mem_busy[d]   <= 1'b1;
        mem_ravail[d] <= 1'b0;
        stub_cnt[d]   <= $urandom_range(4, 1);
        op_we[d]      <= m_we[d];
        op_key[d]     <= {m_bsel[d], m_addr[d][7:0]};
        op_wd[d]      <= m_din[d];
        op_be[d]      <= {m_wh[d], m_wl[d]};
      end else if (mem_busy[d] && !stuck[d]) begin
        if (stub_cnt[d] > 1) stub_cnt[d] <= stub_cnt[d] - 1;
        else begin
          mem_busy[d] <= 1'b0;
          if (op_we[d])
            store[d][op_key[d]] <= (store[d][op_key[d]] & ~lane_mask(op_be[d])) |
                                   (op_wd[d] & lane_mask(op_be[d]));
          else begin
            mem_dout[d]   <= store[d][op_key[d]];
            mem_ravail[d] <= 1'b1;
          end
        end
      end
    end
  end

  // Monitor: logs grants, read responses and strobe statistics per instance.
  int gr_log [2][1024];
  int gr_n   [2] = '{0, 0};
  int rv_port[2][1024];
  logic [15:0] rv_data[2][1024];
  int rv_n   [2] = '{0, 0};
  int wstb_n [2] = '{0, 0};
  int rstb_n [2] = '{0, 0};
  int b2b_n  [2] = '{0, 0};
  logic prev_stb [2] = '{1'b0, 1'b0};
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (p_ack[d][p]) begin
          gr_log[d][gr_n[d] % 1024] <= p;
          gr_n[d] <= gr_n[d] + 1;
        end
        if (p_rvalid[d][p]) begin
          rv_port[d][rv_n[d] % 1024] <= p;
          rv_data[d][rv_n[d] % 1024] <= p_rdata[d];
          rv_n[d] <= rv_n[d] + 1;
        end
      end
      if (m_we[d]) wstb_n[d] <= wstb_n[d] + 1;
      if (m_re[d]) rstb_n[d] <= rstb_n[d] + 1;
      if ((m_we[d] || m_re[d]) && prev_stb[d]) b2b_n[d] <= b2b_n[d] + 1;
      prev_stb[d] <= m_we[d] | m_re[d];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] outs_vec(input int d);
    return {p_ack[d], p_rvalid[d], p_rdata[d], timeout_err[d], m_bsel[d], m_addr[d],
            m_din[d], m_wh[d], m_wl[d], m_we[d], m_re[d]};
  endfunction

  task automatic set_cmd(input int d, input int p, input logic we, input logic bs,
                         input logic [21:0] a, input logic [15:0] wd, input logic [1:0] be);
    p_we[d][p]       = we;
    p_bank_sel[d][p] = bs;
    p_addr[d][p]     = a;
    p_wdata[d][p]    = wd;
    p_be[d][p]       = be;
  endtask

  // Returns the number of cycles until ack is seen, or -1 if none within max_cyc.
  task automatic wait_ack(input int d, input int p, input int max_cyc, output int cyc);
    cyc = -1;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (p_ack[d][p]) begin
        cyc = c;
        break;
      end
    end
  endtask

  // Holds req through n acks (renewing the fields each time), then releases.
  task automatic burst(input int d, input int p, input int n, input logic [21:0] a);
    int cyc;
    p_req[d][p] = 1'b1;
    for (int k = 0; k < n; k++) begin
      set_cmd(d, p, 1'b1, 1'b0, a, 16'(k), 2'b11);
      wait_ack(d, p, 100, cyc);
      check($sformatf("burst_ack_d%0d_p%0d_%0d", d, p, k), 64'(cyc > 0), 64'd1);
      if (cyc < 0) break;
    end
    p_req[d][p] = 1'b0;
  endtask

  // Reference-checked random traffic: port p owns bank p, 8 words, sequential per port.
  logic [15:0] exp_arr[2][64];
  int          exp_n  [2] = '{0, 0};
  task automatic rand_port(input int p, input int nops);
    logic [15:0] mdl [8];
    int cyc, idx;
    logic we;
    logic [15:0] wd;
    logic [1:0] be;
    for (int k = 0; k < nops; k++) begin
      if (k < 8) begin
        we = 1'b1; idx = k; be = 2'b11;
      end else begin
        we = 1'($urandom_range(1, 0)); idx = $urandom_range(7, 0); be = 2'($urandom_range(3, 0));
      end
      wd = 16'($urandom);
      if (we) mdl[idx] = (mdl[idx] & ~lane_mask(be)) | (wd & lane_mask(be));
      else begin
        exp_arr[p][exp_n[p]] = mdl[idx];
        exp_n[p]++;
      end
      set_cmd(0, p, we, 1'(p), 22'h200000 + 22'(idx), wd, be);
      p_req[0][p] = 1'b1;
      wait_ack(0, p, 100, cyc);
      if (cyc < 0) begin
        check($sformatf("rand_ack_p%0d_%0d", p, k), 64'(cyc > 0), 64'd1);
        break;
      end
      if ($urandom_range(1, 0) == 1) begin
        p_req[0][p] = 1'b0;
        repeat ($urandom_range(3, 0)) @(negedge clk);
      end
    end
    p_req[0][p] = 1'b0;
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic        bs;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp;
  } vec_t;

  initial begin
    vec_t tbl [8];
    int cyc, gb, rb, wb, rdb, bb, last_served, first, wcyc, got;
    logic [15:0] rd;
    logic [1:0] stb;

    tbl[0] = '{0, 1'b1, 1'b0, 22'h001234, 16'hBEEF, 2'b11, 16'h0000};
    tbl[1] = '{1, 1'b0, 1'b0, 22'h001234, 16'h0000, 2'b00, 16'hBEEF};
    tbl[2] = '{0, 1'b1, 1'b0, 22'h000042, 16'h1111, 2'b11, 16'h0000};
    tbl[3] = '{1, 1'b1, 1'b0, 22'h000042, 16'hAABB, 2'b01, 16'h0000};
    tbl[4] = '{0, 1'b0, 1'b0, 22'h000042, 16'h0000, 2'b11, 16'h11BB};
    tbl[5] = '{1, 1'b1, 1'b1, 22'h001234, 16'h1357, 2'b11, 16'h0000};
    tbl[6] = '{0, 1'b0, 1'b1, 22'h001234, 16'h0000, 2'b00, 16'h1357};
    tbl[7] = '{0, 1'b0, 1'b0, 22'h001234, 16'h0000, 2'b00, 16'hBEEF};

    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      p_req[d] = '0; p_we[d] = '0; p_bank_sel[d] = '0;
      p_addr[d] = '0; p_wdata[d] = '0; p_be[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("reset_outs_d%0d", d), outs_vec(d), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Table of single operations on the round-robin instance
    for (int i = 0; i < 8; i++) begin
      gb = gr_n[0]; rb = rv_n[0]; wb = wstb_n[0]; rdb = rstb_n[0];
      set_cmd(0, tbl[i].port, tbl[i].we, tbl[i].bs, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      p_req[0][tbl[i].port] = 1'b1;
      wait_ack(0, tbl[i].port, 50, cyc);
      p_req[0][tbl[i].port] = 1'b0;
      @(negedge clk);
      stb = {m_we[0], m_re[0]};
      check($sformatf("vec%0d_ack_latency", i), 64'(cyc), 64'd1);
      check($sformatf("vec%0d_strobe", i), 64'(stb), tbl[i].we ? 64'd2 : 64'd1);
      repeat (12) @(negedge clk);
      check($sformatf("vec%0d_grant", i), {32'(gr_n[0] - gb), 32'(gr_log[0][gb])},
            {32'd1, 32'(tbl[i].port)});
      check($sformatf("vec%0d_strobe_count", i), {32'(wstb_n[0] - wb), 32'(rstb_n[0] - rdb)},
            tbl[i].we ? {32'd1, 32'd0} : {32'd0, 32'd1});
      if (tbl[i].we)
        check($sformatf("vec%0d_no_rvalid", i), 64'(rv_n[0] - rb), 64'd0);
      else
        check($sformatf("vec%0d_rdata", i),
              {16'(rv_n[0] - rb), 16'(rv_port[0][rb]), rv_data[0][rb]},
              {16'd1, 16'(tbl[i].port), tbl[i].exp});
      if (i == 0) check("vec0_model_holds", 64'(store[0][9'h034]), 64'hBEEF);
    end
    last_served = tbl[7].port;

    // Round-robin tie: both ports keep requesting, grants must alternate
    gb = gr_n[0]; bb = b2b_n[0];
    fork
      burst(0, 0, 2, 22'h000080);
      burst(0, 1, 2, 22'h000081);
    join
    repeat (12) @(negedge clk);
    first = 1 - last_served;
    for (int k = 0; k < 4; k++)
      check($sformatf("rr_grant%0d", k), 64'(gr_log[0][gb + k]), 64'((first + k) % 2));
    check("rr_back_to_back_strobes", 64'(b2b_n[0] - bb), 64'd0);

    // Fixed priority: port 1 waits until port 0 stops requesting
    gb = gr_n[1];
    fork
      burst(1, 0, 3, 22'h000090);
      burst(1, 1, 1, 22'h000091);
    join
    repeat (12) @(negedge clk);
    for (int k = 0; k < 4; k++)
      check($sformatf("fp_grant%0d", k), 64'(gr_log[1][gb + k]), (k < 3) ? 64'd0 : 64'd1);

    // Watchdog: controller never drops busy
    stuck[0] = 1'b1;
    set_cmd(0, 0, 1'b0, 1'b0, 22'h001234, 16'h0, 2'b00);
    p_req[0][0] = 1'b1;
    wait_ack(0, 0, 50, cyc);
    p_req[0][0] = 1'b0;
    wcyc = -1; rd = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (p_rvalid[0][0]) begin
        wcyc = c; rd = p_rdata[0];
        break;
      end
    end
    check("wd_abort_latency", 64'(wcyc), 64'd9);
    check("wd_dead_data", 64'(rd), 64'hDEAD);
    check("wd_timeout_err", 64'(timeout_err[0]), 64'd1);
    set_cmd(0, 1, 1'b1, 1'b0, 22'h000050, 16'h7777, 2'b11);
    p_req[0][1] = 1'b1;
    wait_ack(0, 1, 30, cyc);
    check("wd_no_grant_while_busy", 64'(cyc), 64'(-1));
    stuck[0] = 1'b0;
    wait_ack(0, 1, 30, cyc);
    p_req[0][1] = 1'b0;
    check("wd_grant_after_busy", 64'(cyc > 0), 64'd1);
    repeat (12) @(negedge clk);
    check("wd_err_sticky", 64'(timeout_err[0]), 64'd1);

    // Asynchronous reset in the middle of a read
    stuck[0] = 1'b1;
    set_cmd(0, 0, 1'b0, 1'b0, 22'h001234, 16'h0, 2'b00);
    p_req[0][0] = 1'b1;
    wait_ack(0, 0, 50, cyc);
    p_req[0][0] = 1'b0;
    repeat (3) @(negedge clk);
    rb = rv_n[0];
    reset_n = 1'b0;
    #1;
    check("midreset_outs_d0", outs_vec(0), 64'd0);
    check("midreset_outs_d1", outs_vec(1), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    set_cmd(0, 1, 1'b1, 1'b0, 22'h000051, 16'h4444, 2'b11);
    p_req[0][1] = 1'b1;
    wait_ack(0, 1, 20, cyc);
    check("midreset_hold_off", 64'(cyc), 64'(-1));
    stuck[0] = 1'b0;
    wait_ack(0, 1, 30, cyc);
    p_req[0][1] = 1'b0;
    check("midreset_grant_after_drain", 64'(cyc > 0), 64'd1);
    repeat (12) @(negedge clk);
    check("midreset_no_replay", 64'(rv_n[0] - rb), 64'd0);

    // Random concurrent traffic against the per-port memory model
    rb = rv_n[0];
    fork
      rand_port(0, 30);
      rand_port(1, 30);
    join
    repeat (20) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      got = 0;
      for (int j = rb; j < rv_n[0]; j++) begin
        if (rv_port[0][j] == p) begin
          if (got < exp_n[p])
            check($sformatf("rand_p%0d_read%0d", p, got), 64'(rv_data[0][j]), 64'(exp_arr[p][got]));
          got++;
        end
      end
      check($sformatf("rand_p%0d_read_count", p), 64'(got), 64'(exp_n[p]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end

endmodule
